// File: rtl/systolic_mm_stream_pkg.sv
// Shared definitions for the output-stationary systolic matrix multiplier:
// controller state encoding and parameter-derivation helpers.
package systolic_mm_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Product width plus enough headroom for N accumulations without overflow.
  function automatic int calc_acc_w(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int idx_w(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_mm_stream_pe.sv
// One processing element: forwards a to the right and b downward through
// registers, and accumulates a*b in place (output-stationary).
module systolic_pe #(
  parameter int DATA_W = 2,
  parameter int ACC_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};

  // NOTE: state uses non-blocking assignments so every PE samples its
  // neighbour's value from before the edge, which is what makes the wave move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr)
        acc <= '0;
      else if (en)
        acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/systolic_mm_stream.sv
// NxN output-stationary systolic multiplier C = A x B: takes k-slices over
// valid/ready, skews them into the PE grid, drains, then streams C row-major.
module systolic_mm_stream
  import systolic_mm_stream_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 2,
  parameter int ACC_W  = calc_acc_w(N, DATA_W),
  parameter int IDX_W  = idx_w(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_a,
  input  logic [N*DATA_W-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic [IDX_W-1:0]    out_row,
  output logic [IDX_W-1:0]    out_col,
  output logic                out_last,
  output logic                busy
);

  localparam int               FL_W       = $clog2(2 * N);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(2 * N - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] k_cnt;
  logic [FL_W-1:0]  fl_cnt;
  logic             beat;
  logic             clr;
  logic             en;

  // a_h[i][j] feeds PE(i,j) from the left; b_v[i][j] feeds PE(i,j) from above.
  logic [DATA_W-1:0] a_h [N][N+1];
  logic [DATA_W-1:0] b_v [N+1][N];
  logic [ACC_W-1:0]  acc [N][N];

  assign beat = in_valid && in_ready;
  assign clr  = (state == IDLE);
  assign en   = (state == LOAD) || (state == FLUSH);

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_W-1:0] a_inj;
    logic [DATA_W-1:0] b_inj;

    // Non-beat cycles inject zeros, so bubbles contribute nothing to C.
    assign a_inj = beat ? in_a[gi*DATA_W +: DATA_W] : '0;
    assign b_inj = beat ? in_b[gi*DATA_W +: DATA_W] : '0;

    if (gi == 0) begin : g_direct
      assign a_h[0][0] = a_inj;
      assign b_v[0][0] = b_inj;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sr [gi];
      logic [DATA_W-1:0] b_sr [gi];

      // NOTE: the delay lines are reset explicitly; an aborted job must not
      // leave operands in flight that would leak into the next result.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < gi; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_inj;
          b_sr[0] <= b_inj;
          for (int s = 1; s < gi; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end

      assign a_h[gi][0] = a_sr[gi-1];
      assign b_v[0][gi] = b_sr[gi-1];
    end
  end

  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .a_in  (a_h[gr][gc]),
        .b_in  (b_v[gr][gc]),
        .a_out (a_h[gr][gc+1]),
        .b_out (b_v[gr+1][gc]),
        .acc   (acc[gr][gc])
      );
    end
  end

  // Index registers are held at zero outside OUT, so gating on out_valid
  // is enough to keep the result port quiet between jobs.
  assign out_data = out_valid ? acc[out_row][out_col] : '0;
  assign out_last = out_valid && (out_row == IDX_LAST) && (out_col == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      k_cnt     <= '0;
      fl_cnt    <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          k_cnt    <= '0;
        end
        LOAD: begin
          if (beat) begin
            if (k_cnt == IDX_LAST) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
              k_cnt    <= '0;
              fl_cnt   <= '0;
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          // 2N-1 cycles covers the longest skew-plus-pass path to PE(N-1,N-1).
          if (fl_cnt == FLUSH_LAST) begin
            state     <= OUT;
            out_valid <= 1'b1;
            fl_cnt    <= '0;
            out_row   <= '0;
            out_col   <= '0;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_row == IDX_LAST && out_col == IDX_LAST) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_row   <= '0;
              out_col   <= '0;
            end else if (out_col == IDX_LAST) begin
              out_col <= '0;
              out_row <= out_row + 1'b1;
            end else begin
              out_col <= out_col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Bench for systolic_mm_stream: directed N=3 table plus multi-cycle corner
// sequences, then randomized N=4/8-bit jobs against a matrix-product model.
module tb_systolic_mm_stream;

  typedef struct {
    int a[16];
    int b[16];
    int c[16];
    bit tog;
    int stall;
    bit chk_lat;
  } vec_t;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_a_w;
  logic [31:0] in_b_w;

  logic        r3, v3, last3, busy3;
  logic [5:0]  d3;
  logic [1:0]  row3, col3;
  logic        r4, v4, last4, busy4;
  logic [17:0] d4;
  logic [1:0]  row4, col4;

  logic        rdy, ov, olast, obusy;
  logic [31:0] od;
  logic [1:0]  orow, ocol;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] beat_a[$];
  logic [31:0] beat_b[$];
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  systolic_mm_stream #(.N(3), .DATA_W(2)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & ~sel),
    .in_ready  (r3),
    .in_a      (in_a_w[5:0]),
    .in_b      (in_b_w[5:0]),
    .out_valid (v3),
    .out_ready (out_ready & ~sel),
    .out_data  (d3),
    .out_row   (row3),
    .out_col   (col3),
    .out_last  (last3),
    .busy      (busy3)
  );

  systolic_mm_stream #(.N(4), .DATA_W(8)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & sel),
    .in_ready  (r4),
    .in_a      (in_a_w),
    .in_b      (in_b_w),
    .out_valid (v4),
    .out_ready (out_ready & sel),
    .out_data  (d4),
    .out_row   (row4),
    .out_col   (col4),
    .out_last  (last4),
    .busy      (busy4)
  );

  assign rdy   = sel ? r4 : r3;
  assign ov    = sel ? v4 : v3;
  assign olast = sel ? last4 : last3;
  assign obusy = sel ? busy4 : busy3;
  assign od    = sel ? {14'b0, d4} : {26'b0, d3};
  assign orow  = sel ? row4 : row3;
  assign ocol  = sel ? col4 : col3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  rdy,   0);
    check({tag, "_out_valid"}, ov,    0);
    check({tag, "_out_data"},  od,    0);
    check({tag, "_out_row"},   orow,  0);
    check({tag, "_out_col"},   ocol,  0);
    check({tag, "_out_last"},  olast, 0);
    check({tag, "_busy"},      obusy, 0);
  endtask

  // Matrices are stored 4-wide: element (r,c) lives at index r*4+c.
  task automatic push_beats(input int n, input int dw, input int a[16], input int b[16]);
    for (int k = 0; k < n; k++) begin
      logic [31:0] wa = '0;
      logic [31:0] wb = '0;
      for (int i = 0; i < n; i++) begin
        wa |= (32'(a[i*4+k]) & ((32'd1 << dw) - 1)) << (i * dw);
        wb |= (32'(b[k*4+i]) & ((32'd1 << dw) - 1)) << (i * dw);
      end
      beat_a.push_back(wa);
      beat_b.push_back(wb);
    end
  endtask

  task automatic push_exp(input int n, input int c[16]);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        exp_t e;
        e.data = c[i*4+j];
        e.row  = i;
        e.col  = j;
        e.last = (i == n-1) && (j == n-1);
        exp_q.push_back(e);
      end
  endtask

  // Plain matrix product, reduced modulo 2^ACC_W.
  task automatic model(input int n, input int dw, input int a[16], input int b[16], output int c[16]);
    int acc_w = 2 * dw + $clog2(n);
    for (int i = 0; i < 16; i++) c[i] = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(a[i*4+k]) * longint'(b[k*4+j]);
        c[i*4+j] = int'(s % (longint'(1) << acc_w));
      end
  endtask

  // Drives queued beats and consumes queued expectations, one decision per negedge.
  task automatic run_stream(input int n, input bit tog, input int stall_pct, input bit rand_bubble,
                            output int first_beat_cyc, output int first_ov_cyc);
    int   total_beats = beat_a.size();
    int   taken = 0;
    int   budget = 300 * (total_beats / n + 1);
    bit   phase = 1'b1;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_od = '0;
    first_beat_cyc = -1;
    first_ov_cyc = -1;
    while ((beat_a.size() > 0 || exp_q.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (prev_stall) begin
        check("stall_out_valid", ov, 1);
        check("stall_out_data", od, prev_od);
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      if (ov && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (ov && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e = exp_q.pop_front();
          check($sformatf("data(%0d,%0d)", e.row, e.col), od, e.data);
          check($sformatf("row(%0d,%0d)", e.row, e.col), orow, e.row);
          check($sformatf("col(%0d,%0d)", e.row, e.col), ocol, e.col);
          check($sformatf("last(%0d,%0d)", e.row, e.col), olast, e.last);
        end
      end
      prev_stall = ov && !out_ready;
      prev_od = od;
      if (beat_a.size() > 0) begin
        in_valid = tog ? phase : (rand_bubble ? 1'($urandom_range(1)) : 1'b1);
        phase = ~phase;
        in_a_w = beat_a[0];
        in_b_w = beat_b[0];
        if (in_valid && rdy) begin
          // A job's first beat may only be taken once every earlier result is out.
          if (taken % n == 0)
            check("drained_before_load", exp_q.size(), ((total_beats - taken) / n) * n * n);
          if (taken == 0) first_beat_cyc = cyc;
          void'(beat_a.pop_front());
          void'(beat_b.pop_front());
          taken++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    if (budget == 0) check("stream_timeout", 0, 1);
    beat_a.delete();
    beat_b.delete();
    exp_q.delete();
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[3];
    int   fb, fo;
    int   ra[16], rb[16], rc[16];

    tbl[0].a = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,0};
    tbl[0].b = '{1,2,3,0, 0,1,2,0, 3,3,0,0, 0,0,0,0};
    tbl[0].c = '{1,2,3,0, 0,1,2,0, 3,3,0,0, 0,0,0,0};
    tbl[0].tog = 1'b0; tbl[0].stall = 0;  tbl[0].chk_lat = 1'b0;
    tbl[1].a = '{3,3,3,0, 3,3,3,0, 3,3,3,0, 0,0,0,0};
    tbl[1].b = '{3,3,3,0, 3,3,3,0, 3,3,3,0, 0,0,0,0};
    tbl[1].c = '{27,27,27,0, 27,27,27,0, 27,27,27,0, 0,0,0,0};
    tbl[1].tog = 1'b0; tbl[1].stall = 0;  tbl[1].chk_lat = 1'b1;
    tbl[2] = tbl[0];
    tbl[2].tog = 1'b1; tbl[2].stall = 50; tbl[2].chk_lat = 1'b0;

    sel = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a_w = '0;
    in_b_w = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // T1..T3 from the directed table
    for (int v = 0; v < 3; v++) begin
      push_beats(3, 2, tbl[v].a, tbl[v].b);
      push_exp(3, tbl[v].c);
      run_stream(3, tbl[v].tog, tbl[v].stall, 1'b0, fb, fo);
      if (tbl[v].chk_lat) begin
        check("latency_first_valid", fo - fb, 8);
        @(negedge clk);
        check("busy_after_last", obusy, 0);
        check("valid_after_last", ov, 0);
        @(negedge clk);
        check("busy_next_load", obusy, 1);
        check("ready_next_load", rdy, 1);
      end
    end

    // T4: abort a job in FLUSH, then the first job after reset must be clean
    push_beats(3, 2, tbl[1].a, tbl[1].b);
    for (int i = 0; i < 50 && beat_a.size() > 0; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a_w = beat_a[0];
      in_b_w = beat_b[0];
      if (rdy) begin
        void'(beat_a.pop_front());
        void'(beat_b.pop_front());
      end
    end
    check("t4_beats_taken", beat_a.size(), 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_flush_busy", obusy, 1);
    check("t4_flush_ready", rdy, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("t4_reset");
    @(negedge clk);
    reset = 1'b0;
    push_beats(3, 2, tbl[1].a, tbl[1].b);
    push_exp(3, tbl[1].c);
    run_stream(3, 1'b0, 0, 1'b0, fb, fo);

    // T5: two jobs back to back with in_valid held high the whole time
    push_beats(3, 2, tbl[0].a, tbl[0].b);
    push_exp(3, tbl[0].c);
    push_beats(3, 2, tbl[1].a, tbl[1].b);
    push_exp(3, tbl[1].c);
    run_stream(3, 1'b0, 0, 1'b0, fb, fo);

    // T6: N=4, 8-bit random jobs; first job is all-maximum operands
    in_valid = 1'b0;
    sel = 1'b1;
    repeat (2) @(negedge clk);
    for (int job = 0; job < 200; job++) begin
      for (int i = 0; i < 16; i++) begin
        ra[i] = (job == 0) ? 255 : int'($urandom_range(255));
        rb[i] = (job == 0) ? 255 : int'($urandom_range(255));
      end
      model(4, 8, ra, rb, rc);
      push_beats(4, 8, ra, rb);
      push_exp(4, rc);
      run_stream(4, 1'b0, 30, 1'b1, fb, fo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
